axi4_s_w: RTL and testbench

AXI4 slave write-channel responder on the QEMU PCIe bridge. It accepts one AW burst, collects W beats into a DTMP-byte staging buffer with a per-byte strobe map, and presents the completed write to the host (QEMU/DPI) side as one transaction. After the host signals completion, it returns the B response. Only one burst is in flight at a time.

---
 rtl/axi4_s_w.sv | 227 ++++++++++++++++++++++
 tb/tb_axi4_s_w.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_s_w.sv
// AXI4 slave write-channel responder: collects one AW/W burst into a byte staging
// buffer, hands it to the host as a single request, then returns the B response.
module axi4_s_w #(
   parameter int TAGW = 3,
   parameter int ADRW = 64,
   parameter int DATW = 512,
   parameter int STBW = DATW / 8,
   parameter int DTMP = 4096,
   parameter int NSTB = DTMP / STBW
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   // AW channel
   input  logic [TAGW-1:0]   i_s_awid,
   input  logic [ADRW-1:0]   i_s_awaddr,
   input  logic [7:0]        i_s_awlen,
   input  logic [2:0]        i_s_awsize,
   input  logic [1:0]        i_s_awburst,
   input  logic              i_s_awlock,
   input  logic [3:0]        i_s_awcache,
   input  logic [2:0]        i_s_awprot,
   input  logic [3:0]        i_s_awregion,
   input  logic              i_s_awvalid,
   output logic              o_s_awready,
   // W channel
   input  logic [DATW-1:0]   i_s_wdata,
   input  logic [STBW-1:0]   i_s_wstrb,
   input  logic              i_s_wlast,
   input  logic              i_s_wvalid,
   output logic              o_s_wready,
   // B channel
   output logic [TAGW-1:0]   o_s_bid,
   output logic [1:0]        o_s_bresp,
   output logic              o_s_bvalid,
   input  logic              i_s_bready,
   // host side
   output logic              o_wr_valid,
   output logic [ADRW-1:0]   o_wr_addr,
   output logic [TAGW-1:0]   o_wr_id,
   output logic [7:0]        o_wr_len,
   output logic [2:0]        o_wr_size,
   output logic [7:0]        o_wr_data [0:DTMP-1],
   output logic [DTMP-1:0]   o_wr_strb,
   input  logic              i_wr_done
);

   localparam int RW = $clog2(NSTB);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_COMMIT,
      S_RESP
   } state_e;

   state_e            state_q,   state_d;
   logic              awready_q, awready_d;
   logic              wready_q,  wready_d;
   logic              bvalid_q,  bvalid_d;
   logic [TAGW-1:0]   bid_q,     bid_d;
   logic [1:0]        bresp_q,   bresp_d;
   logic              wr_valid_q, wr_valid_d;
   logic [ADRW-1:0]   addr_q,    addr_d;
   logic [TAGW-1:0]   id_q,      id_d;
   logic [7:0]        len_q,     len_d;
   logic [2:0]        size_q,    size_d;
   logic [8:0]        beat_q,    beat_d;
   logic              err_q,     err_d;

   logic [7:0]                  buf_q  [NSTB][STBW];
   logic [NSTB-1:0][STBW-1:0]   strb_q;

   logic          aw_hs;
   logic          w_hs;
   logic          last_beat;
   logic          beat_in;
   logic [RW-1:0] row;

   // Burst attributes the host side does not use.
   logic unused_aw;
   assign unused_aw = &{1'b0, i_s_awburst, i_s_awlock, i_s_awcache, i_s_awprot, i_s_awregion};

   assign aw_hs     = i_s_awvalid && awready_q;
   assign w_hs      = i_s_wvalid && wready_q;
   assign last_beat = (beat_q == {1'b0, len_q});
   assign beat_in   = int'(beat_q) < NSTB;
   assign row       = beat_q[RW-1:0];

   always_comb begin
      // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bid_d      = bid_q;
      bresp_d    = bresp_q;
      wr_valid_d = wr_valid_q;
      addr_d     = addr_q;
      id_d       = id_q;
      len_d      = len_q;
      size_d     = size_q;
      beat_d     = beat_q;
      err_d      = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (aw_hs) begin
               addr_d    = i_s_awaddr;
               id_d      = i_s_awid;
               len_d     = i_s_awlen;
               size_d    = i_s_awsize;
               beat_d    = '0;
               err_d     = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (w_hs) begin
               beat_d = beat_q + 9'd1;
               // Overflowing the staging buffer or a wlast/len disagreement both poison the burst.
               if (!beat_in || (i_s_wlast != last_beat)) begin
                  err_d = 1'b1;
               end
               if (i_s_wlast || last_beat) begin
                  wready_d   = 1'b0;
                  wr_valid_d = 1'b1;
                  state_d    = S_COMMIT;
               end
            end
         end
         S_COMMIT: begin
            if (i_wr_done) begin
               wr_valid_d = 1'b0;
               bvalid_d   = 1'b1;
               bid_d      = id_q;
               bresp_d    = err_q ? 2'b10 : 2'b00;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            if (i_s_bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         awready_q  <= 1'b1;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bid_q      <= '0;
         bresp_q    <= '0;
         wr_valid_q <= 1'b0;
         addr_q     <= '0;
         id_q       <= '0;
         len_q      <= '0;
         size_q     <= '0;
         beat_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bid_q      <= bid_d;
         bresp_q    <= bresp_d;
         wr_valid_q <= wr_valid_d;
         addr_q     <= addr_d;
         id_q       <= id_d;
         len_q      <= len_d;
         size_q     <= size_d;
         beat_q     <= beat_d;
         err_q      <= err_d;
      end
   end

   // NOTE: the staging buffer is reset because its contents are visible on o_wr_data straight out of reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < NSTB; r++) begin
            for (int i = 0; i < STBW; i++) begin
               buf_q[r][i] <= '0;
            end
         end
         strb_q <= '0;
      end else if (aw_hs) begin
         strb_q <= '0;
      end else if (w_hs && beat_in) begin
         for (int i = 0; i < STBW; i++) begin
            if (i_s_wstrb[i]) begin
               buf_q[row][i]  <= i_s_wdata[8*i +: 8];
               strb_q[row][i] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NSTB; r++) begin
         for (int i = 0; i < STBW; i++) begin
            o_wr_data[r*STBW + i] = buf_q[r][i];
         end
      end
   end

   assign o_wr_strb   = strb_q;
   assign o_s_awready = awready_q;
   assign o_s_wready  = wready_q;
   assign o_s_bvalid  = bvalid_q;
   assign o_s_bid     = bid_q;
   assign o_s_bresp   = bresp_q;
   assign o_wr_valid  = wr_valid_q;
   assign o_wr_addr   = addr_q;
   assign o_wr_id     = id_q;
   assign o_wr_len    = len_q;
   assign o_wr_size   = size_q;

endmodule

// File: tb/tb_axi4_s_w.sv
// Bench for axi4_s_w: directed and random bursts, a burst-level reference model
// and a monitor that scores host requests and B responses against queued expectations.
module tb_axi4_s_w;
   localparam int TAGW = 3;
   localparam int ADRW = 64;
   localparam int DATW = 512;
   localparam int STBW = DATW / 8;
   localparam int DTMP = 4096;
   localparam int NSTB = DTMP / STBW;

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic [TAGW-1:0]   i_s_awid;
   logic [ADRW-1:0]   i_s_awaddr;
   logic [7:0]        i_s_awlen;
   logic [2:0]        i_s_awsize;
   logic [1:0]        i_s_awburst;
   logic              i_s_awlock;
   logic [3:0]        i_s_awcache;
   logic [2:0]        i_s_awprot;
   logic [3:0]        i_s_awregion;
   logic              i_s_awvalid;
   logic              o_s_awready;
   logic [DATW-1:0]   i_s_wdata;
   logic [STBW-1:0]   i_s_wstrb;
   logic              i_s_wlast;
   logic              i_s_wvalid;
   logic              o_s_wready;
   logic [TAGW-1:0]   o_s_bid;
   logic [1:0]        o_s_bresp;
   logic              o_s_bvalid;
   logic              i_s_bready;
   logic              o_wr_valid;
   logic [ADRW-1:0]   o_wr_addr;
   logic [TAGW-1:0]   o_wr_id;
   logic [7:0]        o_wr_len;
   logic [2:0]        o_wr_size;
   logic [7:0]        o_wr_data [0:DTMP-1];
   logic [DTMP-1:0]   o_wr_strb;
   logic              i_wr_done;

   axi4_s_w #(.TAGW(TAGW), .ADRW(ADRW), .DATW(DATW), .DTMP(DTMP)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_s_awid(i_s_awid), .i_s_awaddr(i_s_awaddr), .i_s_awlen(i_s_awlen),
      .i_s_awsize(i_s_awsize), .i_s_awburst(i_s_awburst), .i_s_awlock(i_s_awlock),
      .i_s_awcache(i_s_awcache), .i_s_awprot(i_s_awprot), .i_s_awregion(i_s_awregion),
      .i_s_awvalid(i_s_awvalid), .o_s_awready(o_s_awready),
      .i_s_wdata(i_s_wdata), .i_s_wstrb(i_s_wstrb), .i_s_wlast(i_s_wlast),
      .i_s_wvalid(i_s_wvalid), .o_s_wready(o_s_wready),
      .o_s_bid(o_s_bid), .o_s_bresp(o_s_bresp), .o_s_bvalid(o_s_bvalid), .i_s_bready(i_s_bready),
      .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_id(o_wr_id), .o_wr_len(o_wr_len),
      .o_wr_size(o_wr_size), .o_wr_data(o_wr_data), .o_wr_strb(o_wr_strb), .i_wr_done(i_wr_done)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference model: staging image as the host should see it, plus expected transactions.
   typedef struct {
      logic [ADRW-1:0] addr;
      logic [TAGW-1:0] id;
      logic [7:0]      len;
      logic [2:0]      size;
   } wr_exp_t;
   typedef struct {
      logic [TAGW-1:0] id;
      logic [1:0]      resp;
   } b_exp_t;

   logic [7:0] m_buf  [0:DTMP-1];
   logic       m_strb [0:DTMP-1];
   wr_exp_t    wr_q[$];
   b_exp_t     b_q[$];

   logic [DATW-1:0] bd [256];
   logic [STBW-1:0] bs [256];

   int done_delay   = 0;
   int bready_delay = 0;
   int b_count      = 0;

   // Host side: acknowledges a request after done_delay cycles, toggles randomly otherwise.
   initial begin
      int wv_cnt = 0;
      i_wr_done = 1'b0;
      forever begin
         @(negedge i_clk);
         if (o_wr_valid) begin
            wv_cnt++;
            i_wr_done = (wv_cnt > done_delay);
         end else begin
            wv_cnt = 0;
            i_wr_done = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      int bv_cnt = 0;
      i_s_bready = 1'b0;
      forever begin
         @(negedge i_clk);
         if (o_s_bvalid) begin
            bv_cnt++;
            i_s_bready = (bv_cnt > bready_delay);
         end else begin
            bv_cnt = 0;
            i_s_bready = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: scores every host request and B handshake against the queues.
   initial begin
      bit      wr_seen = 0;
      bit      aw_chk  = 0;
      int      wv_cycles = 0;
      int      bv_cycles = 0;
      wr_exp_t cur;
      b_exp_t  be;
      forever begin
         @(negedge i_clk);
         #2;
         if (!i_rst_n) begin
            wr_seen = 0; aw_chk = 0; wv_cycles = 0; bv_cycles = 0;
            continue;
         end
         if (aw_chk) begin
            check("awready_after_b", 64'(o_s_awready), 64'd1);
            aw_chk = 0;
         end
         if (o_wr_valid) begin
            if (!wr_seen) begin
               int dmis = 0;
               int smis = 0;
               if (wr_q.size() == 0) begin
                  check("unexpected_wr_valid", 64'd1, 64'd0);
                  cur = '{default: '0};
               end else begin
                  cur = wr_q.pop_front();
               end
               for (int j = 0; j < DTMP; j++) begin
                  if (o_wr_data[j] !== m_buf[j]) dmis++;
                  if (o_wr_strb[j] !== m_strb[j]) smis++;
               end
               check("wr_data_mismatched_bytes", 64'(dmis), 64'd0);
               check("wr_strb_mismatched_bits", 64'(smis), 64'd0);
               wr_seen = 1;
               wv_cycles = 0;
            end
            check("wr_addr", o_wr_addr, cur.addr);
            check("wr_id", 64'(o_wr_id), 64'(cur.id));
            check("wr_len", 64'(o_wr_len), 64'(cur.len));
            check("wr_size", 64'(o_wr_size), 64'(cur.size));
            wv_cycles++;
            if (i_wr_done) begin
               check("wr_valid_hold_cycles", 64'(wv_cycles), 64'(done_delay + 1));
               wr_seen = 0;
            end
         end
         if (o_s_bvalid) begin
            bv_cycles++;
            if (i_s_bready) begin
               if (b_q.size() == 0) begin
                  check("unexpected_bvalid", 64'd1, 64'd0);
               end else begin
                  be = b_q.pop_front();
                  check("bid", 64'(o_s_bid), 64'(be.id));
                  check("bresp", 64'(o_s_bresp), 64'(be.resp));
               end
               check("bvalid_hold_cycles", 64'(bv_cycles), 64'(bready_delay + 1));
               bv_cycles = 0;
               aw_chk = 1;
               b_count++;
            end
         end
      end
   end

   task automatic fill_random(input int n);
      for (int k = 0; k < n; k++) begin
         for (int w = 0; w < DATW / 32; w++) bd[k][32*w +: 32] = $urandom;
         bs[k] = {$urandom, $urandom};
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < DTMP; j++) begin
         m_buf[j] = '0;
         m_strb[j] = 1'b0;
      end
   endtask

   // One burst. last_at: beat carrying wlast (-1 = never). rst_after >= 0 resets after that many beats.
   task automatic run_burst(input logic [ADRW-1:0] addr, input logic [TAGW-1:0] id,
                            input int len, input logic [2:0] size, input int last_at,
                            input int ddly, input int bdly, input int rst_after, input bit gaps);
      int  term;
      bit  err;
      int  tmo;
      int  target;
      term = (last_at >= 0 && last_at < len) ? last_at : len;
      err  = (last_at != len) || (term >= NSTB);
      if (rst_after < 0) begin
         for (int j = 0; j < DTMP; j++) m_strb[j] = 1'b0;
         for (int k = 0; k <= term && k < NSTB; k++) begin
            for (int i = 0; i < STBW; i++) begin
               if (bs[k][i]) begin
                  m_buf[k*STBW + i]  = bd[k][8*i +: 8];
                  m_strb[k*STBW + i] = 1'b1;
               end
            end
         end
         wr_q.push_back('{addr: addr, id: id, len: 8'(len), size: size});
         b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
      end
      done_delay   = ddly;
      bready_delay = bdly;
      target       = b_count + 1;

      @(negedge i_clk);
      i_s_awvalid = 1'b1; i_s_awaddr = addr; i_s_awid = id;
      i_s_awlen = 8'(len); i_s_awsize = size;
      i_s_awburst = 2'($urandom); i_s_awcache = 4'($urandom);
      tmo = 0;
      while (!o_s_awready && tmo < 100) begin @(negedge i_clk); tmo++; end
      if (tmo >= 100) begin
         check("aw_timeout", 64'd1, 64'd0);
         i_s_awvalid = 1'b0;
         return;
      end
      @(posedge i_clk);
      @(negedge i_clk);
      i_s_awvalid = 1'b0;

      for (int k = 0; k <= term; k++) begin
         if (k == rst_after) begin
            i_s_wvalid = 1'b0;
            i_rst_n = 1'b0;
            #1;
            check("rst_awready", 64'(o_s_awready), 64'd1);
            check("rst_wready", 64'(o_s_wready), 64'd0);
            check("rst_wr_valid", 64'(o_wr_valid), 64'd0);
            check("rst_bvalid", 64'(o_s_bvalid), 64'd0);
            model_reset();
            @(negedge i_clk);
            i_rst_n = 1'b1;
            return;
         end
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               i_s_wvalid = 1'b0;
               @(negedge i_clk);
            end
         end
         i_s_wvalid = 1'b1; i_s_wdata = bd[k]; i_s_wstrb = bs[k];
         i_s_wlast = (k == last_at);
         tmo = 0;
         while (!o_s_wready && tmo < 100) begin @(negedge i_clk); tmo++; end
         if (tmo >= 100) begin
            check("w_timeout", 64'd1, 64'd0);
            i_s_wvalid = 1'b0;
            return;
         end
         @(posedge i_clk);
         @(negedge i_clk);
      end
      i_s_wvalid = 1'b0;
      i_s_wlast  = 1'b0;
      check("wready_drop_after_term", 64'(o_s_wready), 64'd0);

      tmo = 0;
      while (b_count < target && tmo < 500) begin @(negedge i_clk); tmo++; end
      if (tmo >= 500) check("b_timeout", 64'd1, 64'd0);
      @(negedge i_clk);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog_expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      i_rst_n = 1'b0;
      i_s_awid = '0; i_s_awaddr = '0; i_s_awlen = '0; i_s_awsize = '0;
      i_s_awburst = '0; i_s_awlock = 1'b0; i_s_awcache = '0; i_s_awprot = '0;
      i_s_awregion = '0; i_s_awvalid = 1'b0;
      i_s_wdata = '0; i_s_wstrb = '0; i_s_wlast = 1'b0; i_s_wvalid = 1'b0;
      model_reset();
      repeat (3) @(negedge i_clk);
      check("reset_awready", 64'(o_s_awready), 64'd1);
      check("reset_wready", 64'(o_s_wready), 64'd0);
      check("reset_bvalid", 64'(o_s_bvalid), 64'd0);
      check("reset_bid", 64'(o_s_bid), 64'd0);
      check("reset_bresp", 64'(o_s_bresp), 64'd0);
      check("reset_wr_valid", 64'(o_wr_valid), 64'd0);
      check("reset_wr_addr", o_wr_addr, 64'd0);
      check("reset_wr_strb_any", 64'(|o_wr_strb), 64'd0);
      i_rst_n = 1'b1;

      // W beats offered while idle must not be taken.
      i_s_wvalid = 1'b1; i_s_wstrb = '1;
      repeat (2) begin
         @(negedge i_clk);
         check("idle_wready", 64'(o_s_wready), 64'd0);
      end
      i_s_wvalid = 1'b0;

      // Single full-strobe beat, bytes = index.
      for (int b = 0; b < STBW; b++) bd[0][8*b +: 8] = 8'(b);
      bs[0] = '1;
      run_burst(64'h1000, 3'd5, 0, 3'd6, 0, 0, 0, -1, 0);

      // Four beats, only byte 0 and byte 255 written.
      fill_random(4);
      bs[0] = 64'h1; bs[1] = '0; bs[2] = '0; bs[3] = 64'h8000_0000_0000_0000;
      run_burst(64'h2000, 3'd2, 3, 3'd6, 3, 1, 1, -1, 0);

      // Early wlast on beat 1 of a four-beat burst.
      fill_random(4);
      run_burst(64'h3000, 3'd7, 3, 3'd6, 1, 0, 0, -1, 0);

      // wlast never asserted, host and B side stalled.
      fill_random(2);
      run_burst(64'h4000, 3'd1, 1, 3'd6, -1, 5, 4, -1, 0);

      // Overlength burst spills past the staging buffer.
      fill_random(71);
      run_burst(64'h5000, 3'd3, 70, 3'd6, 70, 0, 0, -1, 1);

      // Reset in the middle of a burst, then a clean single beat.
      fill_random(8);
      run_burst(64'h6000, 3'd4, 7, 3'd6, 7, 0, 0, 2, 0);
      fill_random(1);
      run_burst(64'h7000, 3'd6, 0, 3'd6, 0, 0, 0, -1, 0);

      for (int t = 0; t < 20; t++) begin
         int len;
         int last_at;
         int r;
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 80) : $urandom_range(0, 7);
         r = $urandom_range(0, 9);
         if (r < 7)      last_at = len;
         else if (r == 7) last_at = -1;
         else            last_at = (len > 0) ? $urandom_range(0, len - 1) : len;
         fill_random(len + 1);
         run_burst({$urandom, $urandom}, 3'($urandom), len, 3'($urandom), last_at,
                   $urandom_range(0, 3), $urandom_range(0, 3), -1, 1);
      end

      repeat (5) @(negedge i_clk);
      check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
      check("b_queue_drained", 64'(b_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
